// File: rtl/fpbp_input_feeder_if.sv
// Bundle between the FP/BP controller side and the input feeder:
// buffer write port, pass controls, and the skewed PE-row outputs.
interface fpbp_input_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [ROWS*DATA_W-1:0] wr_data;
    logic [1:0]             mode;
    logic                   stride;
    logic                   in_en;
    logic                   pe_rst;
    logic [ROWS*DATA_W-1:0] row_data;
    logic [ROWS-1:0]        row_valid;
    logic                   busy;
    logic                   feed_done;

    modport master (
        output wr_en, wr_addr, wr_data, mode, stride, in_en, pe_rst,
        input  row_data, row_valid, busy, feed_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, mode, stride, in_en, pe_rst,
        output row_data, row_valid, busy, feed_done
    );
endinterface

// File: rtl/fpbp_input_feeder.sv
// Streams one buffered operand tile into the PE array, forward (FP) or reversed (BP),
// with a per-row skew so row r sees each word r cycles after row 0.
module fpbp_input_feeder #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 16,
    parameter int BEATS  = 8
) (
    input logic                clk,
    input logic                rst,
    fpbp_input_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = ROWS * DATA_W;
    localparam int CW = $clog2(BEATS + 1);
    localparam logic [ROWS-1:0] HEAD_MASK = {ROWS{1'b1}} >> 1;
    localparam logic [1:0] MODE_FP = 2'b01;
    localparam logic [1:0] MODE_BP = 2'b10;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [WW-1:0]   mem [DEPTH];
    logic [WW-1:0]   skew_word [ROWS];
    logic [ROWS-1:0] skew_valid;
    logic [AW-1:0]   ptr, rd_addr, step, next_addr;
    logic [CW-1:0]   beat_cnt;
    logic            fp_q, stride_q, cur_fp, cur_stride;
    logic            legal_mode, start, issue;

    // In IDLE the live mode/stride choose the first address; afterwards only the latched copies count.
    always_comb begin
        legal_mode = (bus.mode == MODE_FP) || (bus.mode == MODE_BP);
        start      = (state == IDLE) && bus.in_en && legal_mode && !bus.pe_rst;
        issue      = start || ((state == STREAM) && bus.in_en && !bus.pe_rst);
        cur_fp     = (state == IDLE) ? (bus.mode == MODE_FP) : fp_q;
        cur_stride = (state == IDLE) ? bus.stride : stride_q;
        rd_addr    = (state == IDLE) ? (cur_fp ? '0 : '1) : ptr;
        step       = cur_stride ? AW'(2) : AW'(1);
        next_addr  = cur_fp ? rd_addr + step : rd_addr - step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.pe_rst) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = (BEATS == 1) ? DRAIN : STREAM;
                STREAM:  if (!bus.in_en || beat_cnt == CW'(BEATS - 1)) state_nx = DRAIN;
                // Leave once only the last row still holds a beat; it empties this cycle.
                DRAIN:   if ((skew_valid & HEAD_MASK) == '0) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.feed_done = (state == DONE);
        bus.row_valid = skew_valid;
        bus.row_data  = '0;
        for (int r = 0; r < ROWS; r++)
            bus.row_data[r*DATA_W +: DATA_W] = skew_word[r][r*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            beat_cnt <= '0;
            fp_q     <= 1'b1;
            stride_q <= 1'b0;
        end else if (bus.pe_rst || state == DONE) begin
            ptr      <= '0;
            beat_cnt <= '0;
        end else if (issue) begin
            ptr      <= next_addr;
            beat_cnt <= start ? CW'(1) : beat_cnt + CW'(1);
            if (start) begin
                fp_q     <= cur_fp;
                stride_q <= cur_stride;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    // Stage 0 is the registered buffer read; words flow down one stage per cycle, zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_valid <= '0;
            for (int s = 0; s < ROWS; s++) skew_word[s] <= '0;
        end else if (bus.pe_rst) begin
            skew_valid <= '0;
            for (int s = 0; s < ROWS; s++) skew_word[s] <= '0;
        end else begin
            skew_valid   <= {skew_valid[ROWS-2:0], issue};
            skew_word[0] <= issue ? mem[rd_addr] : '0;
            for (int s = 1; s < ROWS; s++) skew_word[s] <= skew_word[s-1];
        end
    end
endmodule

// File: tb/tb_fpbp_input_feeder.sv
// Scoreboard bench: stimulus pushes per-row expected words with their arrival cycle,
// a negedge monitor pops and compares whenever a row is valid or feed_done fires.
module tb_fpbp_input_feeder;
    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int DEPTH  = 16;
    localparam int NI     = 2;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en   [NI];
    logic [3:0]  wr_addr [NI];
    logic [31:0] wr_data [NI];
    logic [1:0]  mode    [NI];
    logic        stride  [NI];
    logic        in_en   [NI];
    logic        pe_rst  [NI];
    logic [31:0] row_data  [NI];
    logic [3:0]  row_valid [NI];
    logic        busy      [NI];
    logic        feed_done [NI];

    exp_t        row_q  [NI][ROWS][$];
    int          done_q [NI][$];
    int          busy_from [NI];
    int          busy_to   [NI];
    logic [31:0] model [NI][DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    fpbp_input_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) bus0 ();
    fpbp_input_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) bus1 ();

    fpbp_input_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH), .BEATS(8))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    fpbp_input_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH), .BEATS(10))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus0.wr_en   = wr_en[0];
    assign bus0.wr_addr = wr_addr[0];
    assign bus0.wr_data = wr_data[0];
    assign bus0.mode    = mode[0];
    assign bus0.stride  = stride[0];
    assign bus0.in_en   = in_en[0];
    assign bus0.pe_rst  = pe_rst[0];
    assign bus1.wr_en   = wr_en[1];
    assign bus1.wr_addr = wr_addr[1];
    assign bus1.wr_data = wr_data[1];
    assign bus1.mode    = mode[1];
    assign bus1.stride  = stride[1];
    assign bus1.in_en   = in_en[1];
    assign bus1.pe_rst  = pe_rst[1];
    assign row_data[0]  = bus0.row_data;
    assign row_valid[0] = bus0.row_valid;
    assign busy[0]      = bus0.busy;
    assign feed_done[0] = bus0.feed_done;
    assign row_data[1]  = bus1.row_data;
    assign row_valid[1] = bus1.row_valid;
    assign busy[1]      = bus1.busy;
    assign feed_done[1] = bus1.feed_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue the word every row should show for each listed address, then drive in_en once per address.
    task automatic applyStimulus(input int i, input logic [1:0] m, input logic s,
                                 input int addrs[$], input bit toggle);
        int   k;
        int   n;
        exp_t e;
        k = cyc;
        n = addrs.size();
        for (int t = 0; t < n; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                e.cyc  = k + t + 1 + r;
                e.data = model[i][addrs[t]][r*8 +: 8];
                row_q[i][r].push_back(e);
            end
        end
        done_q[i].push_back(k + n + ROWS);
        busy_from[i] = k + 1;
        busy_to[i]   = k + n + ROWS;
        for (int t = 0; t < n; t++) begin
            mode[i]   = (toggle && t > 0) ? ~m : m;
            stride[i] = (toggle && t > 0) ? ~s : s;
            in_en[i]  = 1'b1;
            tick();
        end
        in_en[i] = 1'b0;
    endtask

    task automatic flushExpect(input int i, input int from);
        for (int r = 0; r < ROWS; r++)
            for (int j = row_q[i][r].size() - 1; j >= 0; j--)
                if (row_q[i][r][j].cyc >= from) row_q[i][r].delete(j);
        for (int j = done_q[i].size() - 1; j >= 0; j--)
            if (done_q[i][j] >= from) done_q[i].delete(j);
        if (busy_to[i] >= from) busy_to[i] = from - 1;
    endtask

    task automatic waitIdle(input int i);
        int n;
        n = 0;
        while (busy[i] && n < 50) begin
            tick();
            n++;
        end
        checkOutput($sformatf("d%0d idle after pass", i), {31'd0, busy[i]}, 32'd0);
    endtask

    task automatic loadBuffers();
        for (int a = 0; a < DEPTH; a++) begin
            for (int i = 0; i < NI; i++) begin
                wr_en[i]    = 1'b1;
                wr_addr[i]  = 4'(a);
                wr_data[i]  = {8'(a + 48), 8'(a + 32), 8'(a + 16), 8'(a)};
                model[i][a] = wr_data[i];
            end
            tick();
        end
        for (int i = 0; i < NI; i++) wr_en[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] d;
        int         eb;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                for (int r = 0; r < ROWS; r++) begin
                    d = row_data[i][r*8 +: 8];
                    if (row_valid[i][r]) begin
                        if (row_q[i][r].size() == 0) begin
                            checkOutput($sformatf("d%0d row%0d spurious valid", i, r), 32'd1, 32'd0);
                        end else begin
                            e = row_q[i][r].pop_front();
                            checkOutput($sformatf("d%0d row%0d data", i, r), {24'd0, d}, {24'd0, e.data});
                            checkOutput($sformatf("d%0d row%0d cycle", i, r), cyc, e.cyc);
                        end
                    end else begin
                        checkOutput($sformatf("d%0d row%0d idle data", i, r), {24'd0, d}, 32'd0);
                        if (row_q[i][r].size() > 0 && row_q[i][r][0].cyc <= cyc) begin
                            e = row_q[i][r].pop_front();
                            checkOutput($sformatf("d%0d row%0d missing beat", i, r), 32'd0, 32'd1);
                        end
                    end
                end
                if (feed_done[i]) begin
                    if (done_q[i].size() == 0)
                        checkOutput($sformatf("d%0d spurious feed_done", i), 32'd1, 32'd0);
                    else
                        checkOutput($sformatf("d%0d feed_done cycle", i), cyc, done_q[i].pop_front());
                end else if (done_q[i].size() > 0 && done_q[i][0] <= cyc) begin
                    eb = done_q[i].pop_front();
                    checkOutput($sformatf("d%0d missing feed_done", i), 32'd0, 32'd1);
                end
                eb = (cyc >= busy_from[i] && cyc <= busy_to[i]) ? 1 : 0;
                checkOutput($sformatf("d%0d busy", i), {31'd0, busy[i]}, 32'(eb));
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached, got running, want finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int addrs[$];
        for (int i = 0; i < NI; i++) begin
            wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0; mode[i] = 2'b00;
            stride[i] = 1'b0; in_en[i] = 1'b0; pe_rst[i] = 1'b0;
            busy_from[i] = 1; busy_to[i] = 0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("d%0d reset row_valid", i), {28'd0, row_valid[i]}, 32'd0);
            checkOutput($sformatf("d%0d reset row_data", i), row_data[i], 32'd0);
            checkOutput($sformatf("d%0d reset busy", i), {31'd0, busy[i]}, 32'd0);
            checkOutput($sformatf("d%0d reset feed_done", i), {31'd0, feed_done[i]}, 32'd0);
        end
        #22 rst = 1'b0;
        tick();
        loadBuffers();

        $display("[TB] FP stride 1, full pass");
        addrs = '{0, 1, 2, 3, 4, 5, 6, 7};
        applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
        waitIdle(0);

        $display("[TB] BP stride 2");
        addrs = '{15, 13, 11, 9, 7, 5, 3, 1};
        applyStimulus(0, 2'b10, 1'b1, addrs, 1'b0);
        waitIdle(0);

        $display("[TB] FP stride 2 with wrap, 10 beats");
        addrs = '{0, 2, 4, 6, 8, 10, 12, 14, 0, 2};
        applyStimulus(1, 2'b01, 1'b1, addrs, 1'b0);
        waitIdle(1);

        $display("[TB] short passes, mode/stride toggled mid-pass");
        addrs = '{0, 1, 2};
        applyStimulus(0, 2'b01, 1'b0, addrs, 1'b1);
        waitIdle(0);
        addrs = '{15, 14, 13};
        applyStimulus(1, 2'b10, 1'b0, addrs, 1'b1);
        waitIdle(1);

        $display("[TB] abort with pe_rst");
        addrs = '{0, 1, 2, 3, 4, 5};
        fork
            applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
            begin
                repeat (5) tick();
                pe_rst[0] = 1'b1;
                flushExpect(0, cyc + 1);
                tick();
                pe_rst[0] = 1'b0;
            end
        join
        tick();
        addrs = '{0, 1, 2, 3, 4, 5, 6, 7};
        applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
        waitIdle(0);

        $display("[TB] write/read collision");
        addrs = '{0, 1, 2, 3, 4, 5, 6, 7};
        fork
            applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
            begin
                tick();
                tick();
                wr_en[0] = 1'b1; wr_addr[0] = 4'd2; wr_data[0] = 32'hC3C2C1C0;
                tick();
                wr_en[0] = 1'b0;
                model[0][2] = 32'hC3C2C1C0;
            end
        join
        waitIdle(0);
        applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
        waitIdle(0);

        $display("[TB] illegal start modes");
        mode[0] = 2'b11; in_en[0] = 1'b1;
        tick();
        checkOutput("mode 11 busy", {31'd0, busy[0]}, 32'd0);
        mode[0] = 2'b00;
        tick();
        in_en[0] = 1'b0;
        checkOutput("mode 00 busy", {31'd0, busy[0]}, 32'd0);
        tick();

        $display("[TB] async reset mid-stream");
        fork
            applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
            begin
                repeat (3) tick();
                #2 rst = 1'b1;
                #1;
                checkOutput("arst row_valid", {28'd0, row_valid[0]}, 32'd0);
                checkOutput("arst row_data", row_data[0], 32'd0);
                checkOutput("arst busy", {31'd0, busy[0]}, 32'd0);
                checkOutput("arst feed_done", {31'd0, feed_done[0]}, 32'd0);
                flushExpect(0, cyc);
            end
        join
        #2 rst = 1'b0;
        tick();
        loadBuffers();
        applyStimulus(0, 2'b01, 1'b0, addrs, 1'b0);
        waitIdle(0);

        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < ROWS; r++)
                checkOutput($sformatf("d%0d row%0d leftover beats", i, r), row_q[i][r].size(), 32'd0);
            checkOutput($sformatf("d%0d leftover feed_done", i), done_q[i].size(), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
